// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Shared types for the EX-stage execution units.
//   muldiv_op_e            : RV32M funct3 encodings handled by muldiv_unit
//   muldiv_state_e         : muldiv_unit sequencer states
//   muldiv_signed_operands : which operands an op treats as signed
//                            (bit 1 = rs1, bit 0 = rs2)
// ----------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } muldiv_state_e;

  // MUL only yields the low half, which is sign-agnostic, so it runs unsigned.
  function automatic logic [1:0] muldiv_signed_operands(input muldiv_op_e op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 2'b11;
      OP_MULHSU:               return 2'b10;
      default:                 return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// ----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational conditional two's-complement negation and half selection.
//   lo, hi        : low / high halves of the value
//   negate        : negate the value
//   split_halves  : 1 = halves are independent values (quotient/remainder,
//                   operand magnitude); 0 = {hi,lo} is one 2*XLEN product
//   select_hi     : 1 = return hi half, 0 = return lo half
//   result        : selected, optionally negated half
// ----------------------------------------------------------------------------
module muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] hi,
  input  logic            negate,
  input  logic            split_halves,
  input  logic            select_hi,
  output logic [XLEN-1:0] result
);

  logic            hi_carry;
  logic [XLEN-1:0] lo_neg;
  logic [XLEN-1:0] hi_neg;

  // A 2*XLEN negation is ~x + 1; the +1 only ripples into the high half
  // when the low half is zero.
  assign hi_carry = split_halves | (lo == '0);
  assign lo_neg   = ~lo + XLEN'(1);
  assign hi_neg   = ~hi + XLEN'(hi_carry);

  assign result = select_hi ? (negate ? hi_neg : hi)
                            : (negate ? lo_neg : lo);

endmodule

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. Shift-add multiply and restoring
// divide share one unsigned 2*XLEN accumulator; signs are fixed at the end.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_valid/o_ready         : request handshake (o_ready only in IDLE)
//   i_op, i_rs1, i_rs2      : funct3 and operands
//   i_tag                   : destination tag carried to o_tag
//   i_invalidate            : flush, kills any request in flight
//   o_valid/i_ready         : result handshake
//   o_result, o_tag         : result and its tag
//   o_busy                  : unit is not IDLE
// ----------------------------------------------------------------------------
module muldiv_unit
  import pipeline_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic [XLEN-1:0]  i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_invalidate,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   COUNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e state, state_next;
  muldiv_op_e    op_in, op_q;

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   m_q;
  logic [XLEN-1:0]   start_q;
  logic [CW-1:0]     count;
  logic              neg_q;
  logic              load_q;

  logic              accept;
  logic [1:0]        signed_ops;
  logic              sign_a, sign_b;
  logic              is_div_in, is_rem_in;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   special_result;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] div_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] acc_step;
  logic              out_select_hi;
  logic [XLEN-1:0]   fixed_result;

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign o_valid = (state == DONE);

  assign accept     = i_valid & o_ready & ~i_invalidate;
  assign op_in      = muldiv_op_e'(i_op);
  assign signed_ops = muldiv_signed_operands(op_in);
  assign sign_a     = signed_ops[1] & i_rs1[XLEN-1];
  assign sign_b     = signed_ops[0] & i_rs2[XLEN-1];
  assign is_div_in  = i_op[2];
  assign is_rem_in  = i_op[2] & i_op[1];

  // Cases with a fixed architectural answer bypass the iteration entirely.
  assign div_zero = is_div_in & (i_rs2 == '0);
  assign div_ovf  = is_div_in & ~i_op[0] & (i_rs1 == INT_MIN) & (&i_rs2);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = is_rem_in ? i_rs1 : '1;
    else if (!is_rem_in)
      special_result = i_rs1;
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_mag_a (
    .lo           (i_rs1),
    .hi           ('0),
    .negate       (sign_a),
    .split_halves (1'b1),
    .select_hi    (1'b0),
    .result       (mag_a)
  );

  muldiv_sign_fix #(.XLEN(XLEN)) u_mag_b (
    .lo           (i_rs2),
    .hi           ('0),
    .negate       (sign_b),
    .split_halves (1'b1),
    .select_hi    (1'b0),
    .result       (mag_b)
  );

  // Multiply: multiplier sits in the low half and shifts out LSB-first while
  // the partial product grows in from the top. Divide: dividend shifts out
  // MSB-first into the remainder half; quotient bits enter at the bottom.
  // The trial subtraction keeps the bit shifted out of the top so a
  // remainder of up to 2*divisor still compares correctly.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m_q} : '0);
    div_shift = {acc[2*XLEN-2:0], 1'b0};
    div_trial = {acc[2*XLEN-1], div_shift[2*XLEN-1:XLEN]} - {1'b0, m_q};
    if (op_q[2])
      acc_step = div_trial[XLEN] ? div_shift
                                 : {div_trial[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  // Remainders live in the high half, quotients in the low half.
  assign out_select_hi = op_q[2] ? op_q[1] : (op_q[1:0] != 2'b00);

  muldiv_sign_fix #(.XLEN(XLEN)) u_out_fix (
    .lo           (acc[XLEN-1:0]),
    .hi           (acc[2*XLEN-1:XLEN]),
    .negate       (neg_q),
    .split_halves (op_q[2]),
    .select_hi    (out_select_hi),
    .result       (fixed_result)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // A flush overrides every other transition, including a DONE handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (!load_q && count == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (i_invalidate)
      state_next = IDLE;
  end

  // Accept latches operand magnitudes; the first CALC cycle builds the
  // accumulator from them, and each following cycle performs one step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q     <= OP_MUL;
      o_tag    <= '0;
      o_result <= '0;
      m_q      <= '0;
      start_q  <= '0;
      neg_q    <= 1'b0;
      acc      <= '0;
      count    <= '0;
      load_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= op_in;
      o_tag   <= i_tag;
      m_q     <= is_div_in ? mag_b : mag_a;
      start_q <= is_div_in ? mag_a : mag_b;
      neg_q   <= is_rem_in ? sign_a : (sign_a ^ sign_b);
      load_q  <= 1'b1;
      if (special)
        o_result <= special_result;
      else
        count <= COUNT_INIT;
    end else if (state == CALC) begin
      if (load_q) begin
        acc    <= {{XLEN{1'b0}}, start_q};
        load_q <= 1'b0;
      end else begin
        acc   <= acc_step;
        count <= count - CW'(1);
      end
    end else if (state == FIX) begin
      o_result <= fixed_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit at XLEN = 32 and XLEN = 16. Both
// instances share operand buses; handshake controls are routed to the
// instance picked by sel16, and the checked outputs are muxed the same way.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel16 = 1'b0;

  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b0;
  logic        drv_invalidate = 1'b0;
  logic [2:0]  drv_op = 3'd0;
  logic [31:0] drv_rs1 = '0;
  logic [31:0] drv_rs2 = '0;
  logic [4:0]  drv_tag = '0;

  logic        ready32, valid32, busy32;
  logic [31:0] result32;
  logic [4:0]  tag32;
  logic        ready16, valid16, busy16;
  logic [15:0] result16;
  logic [4:0]  tag16;

  logic        cur_ready, cur_valid, cur_busy;
  logic [31:0] cur_result;
  logic [4:0]  cur_tag;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut32 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (drv_valid & ~sel16),
    .o_ready      (ready32),
    .i_op         (drv_op),
    .i_rs1        (drv_rs1),
    .i_rs2        (drv_rs2),
    .i_tag        (drv_tag),
    .i_invalidate (drv_invalidate & ~sel16),
    .o_valid      (valid32),
    .i_ready      (drv_ready & ~sel16),
    .o_result     (result32),
    .o_tag        (tag32),
    .o_busy       (busy32)
  );

  muldiv_unit #(.XLEN(16), .TAG_W(5)) dut16 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (drv_valid & sel16),
    .o_ready      (ready16),
    .i_op         (drv_op),
    .i_rs1        (drv_rs1[15:0]),
    .i_rs2        (drv_rs2[15:0]),
    .i_tag        (drv_tag),
    .i_invalidate (drv_invalidate & sel16),
    .o_valid      (valid16),
    .i_ready      (drv_ready & sel16),
    .o_result     (result16),
    .o_tag        (tag16),
    .o_busy       (busy16)
  );

  assign cur_ready  = sel16 ? ready16 : ready32;
  assign cur_valid  = sel16 ? valid16 : valid32;
  assign cur_busy   = sel16 ? busy16  : busy32;
  assign cur_result = sel16 ? {16'h0000, result16} : result32;
  assign cur_tag    = sel16 ? tag16 : tag32;

  typedef struct {
    string       name;
    bit          w16;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual === expected)
      passed++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Presents one request and returns just after the accept edge.
  task automatic applyStimulus(input bit w16, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag);
    int guard;
    guard = 0;
    @(negedge clk);
    sel16 = w16;
    #1;
    while (!cur_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cur_ready)
      checkOutput("accept_timeout", {63'd0, cur_ready}, 64'd1);
    drv_op    = op;
    drv_rs1   = a;
    drv_rs2   = b;
    drv_tag   = tag;
    drv_valid = 1'b1;
    @(posedge clk);
    #1 drv_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until o_valid is seen, bounded.
  task automatic awaitResult(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!cur_valid && lat < 100);
  endtask

  task automatic consumeResult(input string name);
    drv_ready = 1'b1;
    @(posedge clk);
    #1 drv_ready = 1'b0;
    checkOutput({name, "_idle"}, {63'd0, cur_busy}, 64'd0);
  endtask

  task automatic runVector(input string name, input bit w16, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [31:0] exp,
                           input int exp_lat);
    int lat;
    applyStimulus(w16, op, a, b, tag);
    awaitResult(lat);
    checkOutput({name, "_lat"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, "_result"}, {32'd0, cur_result}, {32'd0, exp});
    checkOutput({name, "_tag"}, {59'd0, cur_tag}, {59'd0, tag});
    consumeResult(name);
  endtask

  function automatic logic [31:0] refModel(input bit w16, input logic [2:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    int          w;
    logic [63:0] mask, ua, ub, p;
    longint      sa, sb, minv;
    w    = w16 ? 16 : 32;
    mask = w16 ? 64'hFFFF : 64'hFFFF_FFFF;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = w16 ? longint'($signed(a[15:0])) : longint'($signed(a));
    sb   = w16 ? longint'($signed(b[15:0])) : longint'($signed(b));
    minv = w16 ? -64'sd32768 : -64'sd2147483648;
    case (op)
      3'd0: p = ua * ub;
      3'd1: p = 64'(sa * sb) >> w;
      3'd2: p = 64'(sa * longint'(ub)) >> w;
      3'd3: p = (ua * ub) >> w;
      3'd4: if (ub == 0) p = '1;
            else if (sa == minv && sb == -1) p = ua;
            else p = 64'(sa / sb);
      3'd5: p = (ub == 0) ? '1 : ua / ub;
      3'd6: if (ub == 0) p = ua;
            else if (sa == minv && sb == -1) p = '0;
            else p = 64'(sa % sb);
      default: p = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(p & mask);
  endfunction

  function automatic logic [31:0] pickOperand(input bit w16);
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = '1;
      2: v = w16 ? 32'h8000 : 32'h8000_0000;
      3: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return w16 ? {16'd0, v[15:0]} : v;
  endfunction

  initial begin
    int          lat;
    bit          saw_valid;
    logic [2:0]  op;
    logic [31:0] a, b, minv, ones;
    int          exp_lat;

    vecs.push_back('{"mul_neg",     1'b0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34});
    vecs.push_back('{"mulh_min",    1'b0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34});
    vecs.push_back('{"mulhu_max",   1'b0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
    vecs.push_back('{"mulhsu_max",  1'b0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
    vecs.push_back('{"mulh_borrow", 1'b0, 3'd1, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 34});
    vecs.push_back('{"mulh_pos",    1'b0, 3'd1, 32'h00012345, 32'h00100000, 32'h00000012, 34});
    vecs.push_back('{"div_neg",     1'b0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
    vecs.push_back('{"rem_neg",     1'b0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
    vecs.push_back('{"div_negdvsr", 1'b0, 3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    vecs.push_back('{"divu",        1'b0, 3'd5, 32'd100,      32'd7,        32'd14,       34});
    vecs.push_back('{"remu",        1'b0, 3'd7, 32'd100,      32'd7,        32'd2,        34});
    vecs.push_back('{"divu_zero",   1'b0, 3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{"rem_zero",    1'b0, 3'd6, 32'h1234,     32'd0,        32'h1234,     1});
    vecs.push_back('{"div_ovf",     1'b0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{"rem_ovf",     1'b0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1});
    vecs.push_back('{"mulh16",      1'b1, 3'd1, 32'h8000,     32'h8000,     32'h4000,     18});
    vecs.push_back('{"div16",       1'b1, 3'd4, 32'hFFF9,     32'd2,        32'hFFFD,     18});
    vecs.push_back('{"divu_zero16", 1'b1, 3'd5, 32'h1234,     32'd0,        32'hFFFF,     1});

    // Reset state, observed while reset is held.
    repeat (2) @(negedge clk);
    checkOutput("rst_ready",  {63'd0, ready32}, 64'd1);
    checkOutput("rst_valid",  {63'd0, valid32}, 64'd0);
    checkOutput("rst_busy",   {63'd0, busy32},  64'd0);
    checkOutput("rst_result", {32'd0, result32}, 64'd0);
    checkOutput("rst_tag",    {59'd0, tag32},   64'd0);
    checkOutput("rst_ready16", {63'd0, ready16}, 64'd1);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < vecs.size(); i++)
      runVector(vecs[i].name, vecs[i].w16, vecs[i].op, vecs[i].a, vecs[i].b,
                5'(i), vecs[i].exp, vecs[i].lat);

    $display("[TB] flush sequences");
    // Request with a simultaneous flush in IDLE must not be accepted.
    @(negedge clk);
    sel16 = 1'b0;
    drv_op = 3'd0; drv_rs1 = 32'd3; drv_rs2 = 32'd5; drv_tag = 5'd1;
    drv_valid = 1'b1; drv_invalidate = 1'b1;
    @(posedge clk);
    #1 drv_valid = 1'b0; drv_invalidate = 1'b0;
    checkOutput("flush_idle_busy", {63'd0, cur_busy}, 64'd0);

    // Flush during CALC cycle 10.
    applyStimulus(1'b0, 3'd0, 32'h1234, 32'h5678, 5'd3);
    repeat (9) @(posedge clk);
    #1 drv_invalidate = 1'b1;
    @(posedge clk);
    #1 drv_invalidate = 1'b0;
    checkOutput("flush_calc_busy",  {63'd0, cur_busy},  64'd0);
    checkOutput("flush_calc_ready", {63'd0, cur_ready}, 64'd1);
    saw_valid = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1 if (cur_valid) saw_valid = 1'b1;
    end
    checkOutput("flush_no_valid", {63'd0, saw_valid}, 64'd0);
    runVector("mul_after_flush", 1'b0, 3'd0, 32'd3, 32'd5, 5'd9, 32'd15, 34);

    // Flush and handshake together in DONE.
    applyStimulus(1'b0, 3'd5, 32'h1234, 32'd0, 5'd2);
    awaitResult(lat);
    checkOutput("flushdone_lat", 64'(lat), 64'd1);
    drv_ready = 1'b1; drv_invalidate = 1'b1;
    @(posedge clk);
    #1 drv_ready = 1'b0; drv_invalidate = 1'b0;
    checkOutput("flushdone_busy",  {63'd0, cur_busy},  64'd0);
    checkOutput("flushdone_valid", {63'd0, cur_valid}, 64'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 3'd5, 32'd100, 32'd7, 5'd21);
    awaitResult(lat);
    checkOutput("bp_lat", 64'(lat), 64'd34);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 checkOutput("bp_hold", {31'd0, cur_valid, 27'd0, cur_tag},
                     {31'd0, 1'b1, 27'd0, 5'd21});
      checkOutput("bp_result", {32'd0, cur_result}, 64'd14);
    end
    consumeResult("bp");

    $display("[TB] reset mid-CALC");
    applyStimulus(1'b0, 3'd0, 32'hDEAD, 32'hBEEF, 5'd17);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready",  {63'd0, ready32}, 64'd1);
    checkOutput("midrst_valid",  {63'd0, valid32}, 64'd0);
    checkOutput("midrst_busy",   {63'd0, busy32},  64'd0);
    checkOutput("midrst_result", {32'd0, result32}, 64'd0);
    checkOutput("midrst_tag",    {59'd0, tag32},   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] random against reference model");
    for (int w = 0; w < 2; w++) begin
      minv = (w == 1) ? 32'h8000 : 32'h8000_0000;
      ones = (w == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
      for (int n = 0; n < 150; n++) begin
        op = 3'($urandom_range(0, 7));
        a  = pickOperand(w == 1);
        b  = pickOperand(w == 1);
        if (op[2] && (b == 0 || (!op[0] && a == minv && b == ones)))
          exp_lat = 1;
        else
          exp_lat = (w == 1) ? 18 : 34;
        runVector("rand", w == 1, op, a, b, 5'(n), refModel(w == 1, op, a, b), exp_lat);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
